// File: rtl/rat_fetch_pkg.sv
// rat_fetch_pkg: shared widths, fixed fetch addresses and fetch FSM states
package rat_fetch_pkg;
  localparam int ADDR_W = 10;
  localparam int IR_W = 18;
  localparam logic [ADDR_W-1:0] RESET_ADDR = 10'h000;
  localparam logic [ADDR_W-1:0] INTR_ADDR = 10'h3FF;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/prog_fetch_ctrl.sv
// prog_fetch_ctrl: program ROM fetch sequencer with stall replay, redirect, interrupt and halt
// Optional PROG_FETCH_PERF_EN adds RETIRE_CNT/STALL_CNT performance counters.
module prog_fetch_ctrl import rat_fetch_pkg::*; (
  input  logic              CLK,
  input  logic              RST,
  output logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [IR_W-1:0]   PROG_IR,
  output logic [IR_W-1:0]   IR_OUT,
  output logic              IR_VALID,
  output logic [ADDR_W-1:0] IR_PC,
  input  logic              STALL,
  input  logic              BRANCH_EN,
  input  logic [ADDR_W-1:0] BRANCH_ADDR,
  input  logic              INTR_REQ,
  input  logic              INTR_EN,
  output logic              INTR_ACK,
  output logic [ADDR_W-1:0] INTR_RET_ADDR,
  input  logic              HALT_REQ,
  output logic              HALTED
`ifdef PROG_FETCH_PERF_EN
  ,
  output logic [15:0]       RETIRE_CNT,
  output logic [15:0]       STALL_CNT
`endif
);
  fetch_state_t state, state_n;
  logic [ADDR_W-1:0] fetch_q, norm, ret;
  logic accept, take, go_halt;
  always_comb begin
    accept = IR_VALID & ~STALL;
    take = INTR_REQ & INTR_EN & ((state == HALT) | ((state == RUN) & accept));
    go_halt = (state == RUN) & accept & HALT_REQ & ~take;
    norm = BRANCH_EN ? BRANCH_ADDR : IR_PC + ADDR_W'(1);
    // On halt exit the resume point is whatever was frozen for the halted fetch
    ret = state == HALT ? fetch_q : norm;
    PROG_ADDR = state == BOOT ? RESET_ADDR : take ? INTR_ADDR :
                state == HALT ? fetch_q : accept ? norm : IR_PC;
    state_n = state == BOOT ? RUN : go_halt ? HALT : take ? RUN : state;
  end
  assign IR_OUT = PROG_IR;
  assign HALTED = state == HALT;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= BOOT;
    else state <= state_n;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      IR_VALID <= 1'b0;
      IR_PC <= RESET_ADDR;
      INTR_ACK <= 1'b0;
      INTR_RET_ADDR <= '0;
      fetch_q <= RESET_ADDR;
    end else begin
      INTR_ACK <= take;
      if (take) INTR_RET_ADDR <= ret;
      // Halting freezes the not-yet-executed address so the halt exit resumes there
      if (state != HALT || take) begin
        IR_PC <= PROG_ADDR;
        IR_VALID <= ~go_halt;
        fetch_q <= go_halt ? PROG_ADDR : PROG_ADDR + ADDR_W'(1);
      end
    end
  end
`ifdef PROG_FETCH_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RETIRE_CNT <= '0;
      STALL_CNT <= '0;
    end else begin
      if (accept) RETIRE_CNT <= RETIRE_CNT + 16'd1;
      if (IR_VALID & STALL) STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// tb_prog_fetch_ctrl: directed table, reset corner cases and random run against a behavioural model
module tb_prog_fetch_ctrl;
  import rat_fetch_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] prog_addr, ir_pc, branch_addr, intr_ret_addr;
  logic [IR_W-1:0] prog_ir, ir_out;
  logic ir_valid, stall, branch_en, intr_req, intr_en, intr_ack, halt_req, halted;
`ifdef PROG_FETCH_PERF_EN
  logic [15:0] retire_cnt, stall_cnt;
`endif
  prog_fetch_ctrl dut (
    .CLK(clk), .RST(rst), .PROG_ADDR(prog_addr), .PROG_IR(prog_ir), .IR_OUT(ir_out),
    .IR_VALID(ir_valid), .IR_PC(ir_pc), .STALL(stall), .BRANCH_EN(branch_en),
    .BRANCH_ADDR(branch_addr), .INTR_REQ(intr_req), .INTR_EN(intr_en), .INTR_ACK(intr_ack),
    .INTR_RET_ADDR(intr_ret_addr), .HALT_REQ(halt_req),
`ifdef PROG_FETCH_PERF_EN
    .RETIRE_CNT(retire_cnt), .STALL_CNT(stall_cnt),
`endif
    .HALTED(halted)
  );
  function automatic logic [IR_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return {a[7:0] ^ 8'h5A, a};
  endfunction
  always @(posedge clk) prog_ir <= rom_word(prog_addr);
  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  // behavioural model: 0 = booting, 1 = executing, 2 = halted
  int m_phase;
  logic [ADDR_W-1:0] m_pc, m_ret, m_resume;
  logic m_valid, m_ack;
  logic [15:0] m_retire, m_stalls;
  function automatic logic [ADDR_W-1:0] m_target();
    return branch_en ? branch_addr : ADDR_W'((int'(m_pc) + 1) % 1024);
  endfunction
  function automatic logic [ADDR_W-1:0] m_addr();
    if (m_phase == 0) return RESET_ADDR;
    if (m_phase == 2) return (intr_req && intr_en) ? INTR_ADDR : m_resume;
    if (stall) return m_pc;
    return (intr_req && intr_en) ? INTR_ADDR : m_target();
  endfunction
  task automatic m_reset();
    m_phase = 0; m_pc = RESET_ADDR; m_ret = '0; m_resume = RESET_ADDR;
    m_valid = 1'b0; m_ack = 1'b0; m_retire = '0; m_stalls = '0;
  endtask
  task automatic m_step();
    logic [ADDR_W-1:0] t;
    m_ack = 1'b0;
    if (m_valid && stall) m_stalls++;
    if (m_phase == 0) begin
      m_phase = 1; m_valid = 1'b1; m_pc = RESET_ADDR;
    end else if (m_phase == 2) begin
      if (intr_req && intr_en) begin
        m_phase = 1; m_valid = 1'b1; m_pc = INTR_ADDR; m_ack = 1'b1; m_ret = m_resume;
      end
    end else if (!stall) begin
      t = m_target();
      m_retire++;
      if (intr_req && intr_en) begin
        m_ret = t; m_pc = INTR_ADDR; m_ack = 1'b1;
      end else if (halt_req) begin
        m_phase = 2; m_valid = 1'b0; m_resume = t;
      end else m_pc = t;
    end
  endtask
  task automatic cycle();
    #1;
    chk("addr", 32'(prog_addr), 32'(m_addr()));
    chk("valid", 32'(ir_valid), 32'(m_valid));
    if (m_valid) begin
      chk("pc", 32'(ir_pc), 32'(m_pc));
      chk("ir", 32'(ir_out), 32'(rom_word(m_pc)));
    end
    chk("ack", 32'(intr_ack), 32'(m_ack));
    chk("ret", 32'(intr_ret_addr), 32'(m_ret));
    chk("halted", 32'(halted), 32'(m_phase == 2));
`ifdef PROG_FETCH_PERF_EN
    chk("retire_cnt", 32'(retire_cnt), 32'(m_retire));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
`endif
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask
  task automatic set_in(input logic s, input logic be, input logic [ADDR_W-1:0] ba,
                        input logic iq, input logic ie, input logic hr);
    stall = s; branch_en = be; branch_addr = ba; intr_req = iq; intr_en = ie; halt_req = hr;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, '0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_reset_now(input string tag);
    chk({tag, "_valid"}, 32'(ir_valid), 0);
    chk({tag, "_pc"}, 32'(ir_pc), 32'(RESET_ADDR));
    chk({tag, "_addr"}, 32'(prog_addr), 32'(RESET_ADDR));
    chk({tag, "_ack"}, 32'(intr_ack), 0);
    chk({tag, "_ret"}, 32'(intr_ret_addr), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
  endtask
  typedef struct {
    logic s, be; logic [ADDR_W-1:0] ba; logic iq, ie, hr;
    logic [ADDR_W-1:0] e_addr; logic e_valid; logic [ADDR_W-1:0] e_pc;
    logic e_ack; logic [ADDR_W-1:0] e_ret; logic e_halted;
  } vec_t;
  vec_t tbl[24];
  function automatic vec_t mk(input logic s, be, input logic [ADDR_W-1:0] ba, input logic iq, ie, hr,
                              input logic [ADDR_W-1:0] ea, input logic ev, input logic [ADDR_W-1:0] ep,
                              input logic ek, input logic [ADDR_W-1:0] er, input logic eh);
    vec_t v;
    v.s = s; v.be = be; v.ba = ba; v.iq = iq; v.ie = ie; v.hr = hr;
    v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_ack = ek; v.e_ret = er; v.e_halted = eh;
    return v;
  endfunction
  initial begin
    tbl[0]  = mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 0, 10'h000, 0, 10'h000, 0);
    tbl[1]  = mk(0, 0, 10'h000, 0, 0, 0, 10'h001, 1, 10'h000, 0, 10'h000, 0);
    tbl[2]  = mk(0, 1, 10'h042, 0, 0, 0, 10'h042, 1, 10'h001, 0, 10'h000, 0);
    tbl[3]  = mk(1, 0, 10'h000, 0, 0, 0, 10'h042, 1, 10'h042, 0, 10'h000, 0);
    tbl[4]  = mk(1, 0, 10'h000, 0, 0, 0, 10'h042, 1, 10'h042, 0, 10'h000, 0);
    tbl[5]  = mk(1, 1, 10'h010, 0, 0, 0, 10'h042, 1, 10'h042, 0, 10'h000, 0);
    tbl[6]  = mk(0, 0, 10'h000, 0, 0, 0, 10'h043, 1, 10'h042, 0, 10'h000, 0);
    tbl[7]  = mk(0, 0, 10'h000, 0, 0, 0, 10'h044, 1, 10'h043, 0, 10'h000, 0);
    tbl[8]  = mk(0, 1, 10'h080, 1, 1, 0, 10'h3FF, 1, 10'h044, 0, 10'h000, 0);
    tbl[9]  = mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h3FF, 1, 10'h080, 0);
    tbl[10] = mk(0, 1, 10'h044, 0, 0, 0, 10'h044, 1, 10'h000, 0, 10'h080, 0);
    tbl[11] = mk(0, 1, 10'h080, 1, 0, 0, 10'h080, 1, 10'h044, 0, 10'h080, 0);
    tbl[12] = mk(0, 1, 10'h045, 0, 0, 0, 10'h045, 1, 10'h080, 0, 10'h080, 0);
    tbl[13] = mk(0, 1, 10'h040, 0, 0, 0, 10'h040, 1, 10'h045, 0, 10'h080, 0);
    tbl[14] = mk(0, 1, 10'h3FE, 0, 0, 0, 10'h3FE, 1, 10'h040, 0, 10'h080, 0);
    tbl[15] = mk(0, 0, 10'h000, 0, 0, 0, 10'h3FF, 1, 10'h3FE, 0, 10'h080, 0);
    tbl[16] = mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h3FF, 0, 10'h080, 0);
    tbl[17] = mk(0, 1, 10'h046, 0, 0, 0, 10'h046, 1, 10'h000, 0, 10'h080, 0);
    tbl[18] = mk(0, 0, 10'h000, 0, 0, 1, 10'h047, 1, 10'h046, 0, 10'h080, 0);
    tbl[19] = mk(0, 0, 10'h000, 0, 0, 0, 10'h047, 0, 10'h000, 0, 10'h080, 1);
    tbl[20] = mk(1, 0, 10'h000, 1, 0, 1, 10'h047, 0, 10'h000, 0, 10'h080, 1);
    tbl[21] = mk(0, 0, 10'h000, 1, 1, 0, 10'h3FF, 0, 10'h000, 0, 10'h080, 1);
    tbl[22] = mk(0, 0, 10'h000, 0, 0, 0, 10'h000, 1, 10'h3FF, 1, 10'h047, 0);
    tbl[23] = mk(0, 0, 10'h000, 0, 0, 0, 10'h001, 1, 10'h000, 0, 10'h047, 0);
    set_in(0, 0, '0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i].s, tbl[i].be, tbl[i].ba, tbl[i].iq, tbl[i].ie, tbl[i].hr);
      #1;
      chk($sformatf("t%0d_addr", i), 32'(prog_addr), 32'(tbl[i].e_addr));
      chk($sformatf("t%0d_valid", i), 32'(ir_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("t%0d_pc", i), 32'(ir_pc), 32'(tbl[i].e_pc));
      chk($sformatf("t%0d_ack", i), 32'(intr_ack), 32'(tbl[i].e_ack));
      chk($sformatf("t%0d_ret", i), 32'(intr_ret_addr), 32'(tbl[i].e_ret));
      chk($sformatf("t%0d_halted", i), 32'(halted), 32'(tbl[i].e_halted));
      cycle();
    end
    // reset while halted must clear outputs without waiting for a clock edge
    set_in(0, 0, '0, 0, 0, 1);
    cycle();
    set_in(0, 0, '0, 0, 0, 0);
    cycle();
    #2 rst = 1'b1;
    #1 chk_reset_now("halt_rst");
    do_reset();
    cycle();
    // reset during a stall with a redirect pending drops the redirect
    set_in(1, 1, 10'h123, 0, 0, 0);
    cycle();
    #2 rst = 1'b1;
    #1 chk_reset_now("stall_rst");
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, ADDR_W'($urandom),
             $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
